// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data, occupancy count, almost flags
// and one-cycle overflow/underflow pulses.
module fifo_sync #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_LVL = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL = CW'(AE_LEVEL);
    localparam logic [CW-1:0] PTR_ONE = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_accept;
    logic             rd_accept;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign dout      = dout_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        rd_accept   = rd_en && !empty;
        // A read in the same cycle frees the slot a full FIFO would otherwise refuse.
        wr_accept   = wr_en && (!full || rd_accept);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dout_d      = dout_q;
        overflow_d  = wr_en && full && !rd_en;
        underflow_d = rd_en && empty;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync (WIDTH=8, DEPTH=16).
module tb_fifo_sync;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks;
    int failures;
    int ov_pulses;
    int un_pulses;
    int exp_cnt;

    fifo_sync #(.WIDTH(8), .DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ov_pulses = 0;
        un_pulses = 0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        din       = 8'h00;
        reset     = 1'b0;

        // Reset
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);

        // Overfill: 20 writes of 0x01..0x14
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            exp_cnt = (i > 16) ? 16 : i;
            check("fill_count", 32'(count), 32'(exp_cnt));
            check("fill_full", 32'(full), 32'(i >= 16));
            check("fill_ovf", 32'(overflow), 32'(i > 16));
            check("fill_af", 32'(almost_full), 32'(exp_cnt >= 14));
            check("fill_ae", 32'(almost_empty), 32'(exp_cnt <= 2));
            if (overflow) ov_pulses++;
        end
        check("ovf_pulses", 32'(ov_pulses), 32'd4);

        // Over-drain: 20 reads
        for (int j = 1; j <= 20; j++) begin
            cycle(1'b0, 1'b1, 8'h00);
            exp_cnt = (j > 16) ? 0 : 16 - j;
            check("drain_dout", 32'(dout), (j > 16) ? 32'h10 : 32'(j));
            check("drain_count", 32'(count), 32'(exp_cnt));
            check("drain_empty", 32'(empty), 32'(j >= 16));
            check("drain_unf", 32'(underflow), 32'(j > 16));
            check("drain_ovf", 32'(overflow), 32'd0);
            if (underflow) un_pulses++;
        end
        check("unf_pulses", 32'(un_pulses), 32'd4);
        cycle(1'b0, 1'b0, 8'h00);
        check("unf_clear", 32'(underflow), 32'd0);
        check("dout_hold", 32'(dout), 32'h10);

        // Wrap-around: write 10, read 10, write 16, read 16
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        check("wrap_cnt10", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("wrap_rd10", 32'(dout), 32'(8'h30 + i));
        end
        check("wrap_empty10", 32'(empty), 32'd1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
        check("wrap_full16", 32'(full), 32'd1);
        check("wrap_notempty", 32'(empty), 32'd0);
        check("wrap_cnt16", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("wrap_rd16", 32'(dout), 32'(8'h50 + i));
        end
        check("wrap_empty16", 32'(empty), 32'd1);
        check("wrap_notfull", 32'(full), 32'd0);

        // Simultaneous access while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        check("sim_full_pre", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 8'hAA);
        check("sim_full_dout", 32'(dout), 32'h60);
        check("sim_full_cnt", 32'(count), 32'd16);
        check("sim_full_flag", 32'(full), 32'd1);
        check("sim_full_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            check("sim_full_rd", 32'(dout), (i == 16) ? 32'hAA : 32'(8'h60 + i));
        end
        check("sim_full_empty", 32'(empty), 32'd1);

        // Simultaneous access while empty
        cycle(1'b1, 1'b1, 8'h77);
        check("sim_empty_cnt", 32'(count), 32'd1);
        check("sim_empty_unf", 32'(underflow), 32'd1);
        check("sim_empty_flag", 32'(empty), 32'd0);
        check("sim_empty_dout", 32'(dout), 32'hAA);
        cycle(1'b0, 1'b1, 8'h00);
        check("sim_empty_rd", 32'(dout), 32'h77);
        check("sim_empty_cnt0", 32'(count), 32'd0);

        // Async reset mid-stream with count=7
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
        cycle(1'b0, 1'b1, 8'h00);
        check("ar_pre_cnt", 32'(count), 32'd7);
        check("ar_pre_dout", 32'(dout), 32'h90);
        #2;
        reset = 1'b0;
        #1;
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_count", 32'(count), 32'd0);
        check("ar_dout", 32'(dout), 32'd0);
        check("ar_full", 32'(full), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ar_post_cnt", 32'(count), 32'd0);
        cycle(1'b1, 1'b0, 8'hC3);
        cycle(1'b0, 1'b1, 8'h00);
        check("ar_post_rd", 32'(dout), 32'hC3);
        check("ar_post_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
